// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-pass shift sequencer: state encoding and
// shift-word field layout.
package shift_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DIR_POS = 0;
   localparam int AMT_LSB = 1;

   // Fill bit is the MSB of the shift word; the amount field sits between it and dir.
   function automatic int fill_pos(input int width);
      return width - 1;
   endfunction

endpackage

// File: rtl/shift_word_pack.sv
// Clamps the remaining amount to one pass and packs it with fill/dir into the
// control word for the shift stage.
module shift_word_pack
   import shift_sequencer_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int STEP_MAX = 3,
   parameter int AMT_W    = 4
) (
   input  logic [AMT_W-1:0] rem_amt,
   input  logic             dir,
   input  logic             fill,
   output logic [AMT_W-1:0] step,
   output logic [WIDTH-1:0] word,
   output logic             last
);

   logic [WIDTH-3:0] amt_field;

   always_comb begin
      last      = (rem_amt <= AMT_W'(STEP_MAX));
      step      = last ? rem_amt : AMT_W'(STEP_MAX);
      amt_field = (WIDTH-2)'(step);
      word      = '0;
      word[DIR_POS]                      = dir;
      word[fill_pos(WIDTH)]              = fill;
      word[fill_pos(WIDTH)-1:AMT_LSB]    = amt_field;
   end

endmodule

// File: rtl/shift_sequencer.sv
// Splits a long shift request into passes of at most STEP_MAX bits, drives an
// external combinational shift stage once per pass and returns the final word.
module shift_sequencer
   import shift_sequencer_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int STEP_MAX = 3,
   parameter int AMT_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_data,
   input  logic [AMT_W-1:0] req_amt,
   input  logic             req_dir,
   input  logic             req_fill,
   output logic [WIDTH-1:0] sh_in,
   output logic [WIDTH-1:0] sh_word,
   input  logic [WIDTH-1:0] sh_out,
   input  logic [WIDTH-1:0] sh_ovf,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic [WIDTH-1:0] rsp_ovf,
   output logic [AMT_W-1:0] rsp_passes
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] ovf_q, ovf_d;
   logic [AMT_W-1:0] rem_q, rem_d;
   logic [AMT_W-1:0] passes_q, passes_d;
   logic             dir_q, dir_d;
   logic             fill_q, fill_d;

   logic [AMT_W-1:0] step;
   logic [WIDTH-1:0] word;
   logic             last;

   shift_word_pack #(
      .WIDTH    (WIDTH),
      .STEP_MAX (STEP_MAX),
      .AMT_W    (AMT_W)
   ) u_pack (
      .rem_amt (rem_q),
      .dir     (dir_q),
      .fill    (fill_q),
      .step    (step),
      .word    (word),
      .last    (last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         ovf_q    <= '0;
         rem_q    <= '0;
         passes_q <= '0;
         dir_q    <= 1'b0;
         fill_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         ovf_q    <= ovf_d;
         rem_q    <= rem_d;
         passes_q <= passes_d;
         dir_q    <= dir_d;
         fill_q   <= fill_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      ovf_d      = ovf_q;
      rem_d      = rem_q;
      passes_d   = passes_q;
      dir_d      = dir_q;
      fill_d     = fill_q;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      rsp_data   = '0;
      rsp_ovf    = '0;
      rsp_passes = '0;
      sh_in      = '0;
      sh_word    = '0;

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               acc_d    = req_data;
               rem_d    = req_amt;
               dir_d    = req_dir;
               fill_d   = req_fill;
               ovf_d    = '0;
               passes_d = '0;
               state_d  = (req_amt == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            // Stage is combinational: its result is captured on this same edge.
            sh_in    = acc_q;
            sh_word  = word;
            acc_d    = sh_out;
            ovf_d    = ovf_q | sh_ovf;
            rem_d    = rem_q - step;
            passes_d = passes_q + AMT_W'(1);
            if (last) state_d = DONE;
         end
         DONE: begin
            rsp_valid  = 1'b1;
            rsp_data   = acc_q;
            rsp_ovf    = ovf_q;
            rsp_passes = passes_q;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural shift stage in the loop.
module tb_shift_sequencer;

   localparam int WIDTH    = 4;
   localparam int STEP_MAX = 3;
   localparam int AMT_W    = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [WIDTH-1:0] req_data = '0;
   logic [AMT_W-1:0] req_amt = '0;
   logic             req_dir = 1'b0;
   logic             req_fill = 1'b0;
   logic [WIDTH-1:0] sh_in, sh_word, sh_out, sh_ovf;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [WIDTH-1:0] rsp_data, rsp_ovf;
   logic [AMT_W-1:0] rsp_passes;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   shift_sequencer #(.WIDTH(WIDTH), .STEP_MAX(STEP_MAX), .AMT_W(AMT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_data   (req_data),
      .req_amt    (req_amt),
      .req_dir    (req_dir),
      .req_fill   (req_fill),
      .sh_in      (sh_in),
      .sh_word    (sh_word),
      .sh_out     (sh_out),
      .sh_ovf     (sh_ovf),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_ovf    (rsp_ovf),
      .rsp_passes (rsp_passes)
   );

   // Shift stage model: word = {fill, amt[1:0], dir}; dir 0 = left, 1 = right;
   // fill enters the vacated bits, overflow flags the input bits shifted out.
   function automatic logic [7:0] shift_model(input logic [3:0] din, input logic [3:0] w);
      logic [1:0] a;
      logic [3:0] o, v, lo_mask, hi_mask;
      a       = w[2:1];
      lo_mask = 4'((5'd1 << a) - 5'd1);
      hi_mask = ~(4'hF >> a);
      if (!w[0]) begin
         o = (din << a) | (w[3] ? lo_mask : 4'h0);
         v = din & hi_mask;
      end else begin
         o = (din >> a) | (w[3] ? hi_mask : 4'h0);
         v = din & lo_mask;
      end
      return {v, o};
   endfunction

   logic       force_ovf = 1'b0;
   logic [3:0] tb_pass;
   logic [3:0] word_log [0:15];
   logic [7:0] model_res;

   always_comb begin
      model_res = shift_model(sh_in, sh_word);
      sh_out    = model_res[3:0];
      if (force_ovf)
         sh_ovf = (tb_pass == 4'd0) ? 4'b0001 : (tb_pass == 4'd1) ? 4'b0100 : 4'b0000;
      else
         sh_ovf = model_res[7:4];
   end

   // Pass index restarts on each accept; every nonzero shift word is logged.
   always @(posedge clk or posedge rst) begin
      if (rst) tb_pass <= '0;
      else if (req_valid && req_ready) tb_pass <= '0;
      else if (sh_word != '0) begin
         word_log[tb_pass] <= sh_word;
         tb_pass           <= tb_pass + 4'd1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issue one request, wait for rsp_valid; returns cycles waited after accept.
   task automatic issue(input logic [3:0] d, input logic [3:0] amt, input logic dr,
                        input logic fl, output int waited);
      @(negedge clk);
      req_valid = 1'b1; req_data = d; req_amt = amt; req_dir = dr; req_fill = fl;
      @(negedge clk);
      req_valid = 1'b0;
      waited = 0;
      while (!rsp_valid && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      if (!rsp_valid) begin
         n_checks++; n_fail++;
         $display("FAIL timeout: rsp_valid never rose for amt %0d", amt);
      end
   endtask

   task automatic release_rsp();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   typedef struct {
      logic [3:0] data;
      logic [3:0] amt;
      logic       dir;
      logic       fill;
      logic [3:0] exp_data;
      logic [3:0] exp_ovf;
      logic [3:0] exp_passes;
   } vec_t;

   vec_t vecs [9];

   initial begin
      int w;
      logic [3:0] hold_d, hold_o, hold_p;

      vecs[0] = '{4'b1011, 4'd0,  1'b0, 1'b0, 4'b1011, 4'b0000, 4'd0};
      vecs[1] = '{4'b0001, 4'd2,  1'b0, 1'b0, 4'b0100, 4'b0000, 4'd1};
      vecs[2] = '{4'b1011, 4'd3,  1'b1, 1'b0, 4'b0001, 4'b0011, 4'd1};
      vecs[3] = '{4'b0110, 4'd4,  1'b0, 1'b0, 4'b0000, 4'b0110, 4'd2};
      vecs[4] = '{4'b1001, 4'd5,  1'b1, 1'b1, 4'b1111, 4'b0011, 4'd2};
      vecs[5] = '{4'b0101, 4'd7,  1'b0, 1'b1, 4'b1111, 4'b1110, 4'd3};
      vecs[6] = '{4'b1100, 4'd1,  1'b1, 1'b0, 4'b0110, 4'b0000, 4'd1};
      vecs[7] = '{4'b0011, 4'd6,  1'b0, 1'b0, 4'b0000, 4'b1010, 4'd2};
      vecs[8] = '{4'b1111, 4'd15, 1'b1, 1'b0, 4'b0000, 4'b0111, 4'd5};

      #1;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_sh_word", 32'(sh_word), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         issue(vecs[i].data, vecs[i].amt, vecs[i].dir, vecs[i].fill, w);
         check($sformatf("v%0d_latency", i), 32'(w), 32'(vecs[i].exp_passes));
         check($sformatf("v%0d_data", i), 32'(rsp_data), 32'(vecs[i].exp_data));
         check($sformatf("v%0d_ovf", i), 32'(rsp_ovf), 32'(vecs[i].exp_ovf));
         check($sformatf("v%0d_passes", i), 32'(rsp_passes), 32'(vecs[i].exp_passes));
         check($sformatf("v%0d_ready_in_done", i), 32'(req_ready), 32'd0);
         check($sformatf("v%0d_shword_in_done", i), 32'(sh_word), 32'd0);
         if (i == 0) check("amt0_no_pass", 32'(tb_pass), 32'd0);
         if (i == 5) begin
            check("amt7_word0", 32'(word_log[0]), 32'b1110);
            check("amt7_word1", 32'(word_log[1]), 32'b1110);
            check("amt7_word2", 32'(word_log[2]), 32'b1010);
         end
         release_rsp();
         check($sformatf("v%0d_back_idle", i), 32'(req_ready), 32'd1);
      end

      // Overflow OR across passes with injected per-pass flags.
      force_ovf = 1'b1;
      issue(4'b0000, 4'd5, 1'b0, 1'b0, w);
      check("ovf_or", 32'(rsp_ovf), 32'b0101);
      check("ovf_passes", 32'(rsp_passes), 32'd2);
      release_rsp();
      force_ovf = 1'b0;

      // Backpressure: response held, new requests ignored.
      issue(4'b0001, 4'd2, 1'b0, 1'b0, w);
      hold_d = rsp_data; hold_o = rsp_ovf; hold_p = rsp_passes;
      check("bp_data", 32'(hold_d), 32'b0100);
      req_valid = 1'b1; req_data = 4'b1111; req_amt = 4'd0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("bp_valid_%0d", c), 32'(rsp_valid), 32'd1);
         check($sformatf("bp_stable_%0d", c), 32'({rsp_data, rsp_ovf, rsp_passes}),
               32'({hold_d, hold_o, hold_p}));
         check($sformatf("bp_ready_%0d", c), 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      release_rsp();
      check("bp_release_idle", 32'(req_ready), 32'd1);
      check("bp_release_valid", 32'(rsp_valid), 32'd0);

      // Reset in the middle of a multi-pass operation.
      @(negedge clk);
      req_valid = 1'b1; req_data = 4'b0101; req_amt = 4'd9; req_dir = 1'b0; req_fill = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_ready", 32'(req_ready), 32'd1);
      check("mid_rst_valid", 32'(rsp_valid), 32'd0);
      check("mid_rst_sh", 32'({sh_in, sh_word}), 32'd0);
      check("mid_rst_rsp", 32'({rsp_data, rsp_ovf, rsp_passes}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check($sformatf("post_rst_novalid_%0d", c), 32'(rsp_valid), 32'd0);
      end
      issue(vecs[3].data, vecs[3].amt, vecs[3].dir, vecs[3].fill, w);
      check("post_rst_data", 32'(rsp_data), 32'(vecs[3].exp_data));
      check("post_rst_ovf", 32'(rsp_ovf), 32'(vecs[3].exp_ovf));
      check("post_rst_passes", 32'(rsp_passes), 32'(vecs[3].exp_passes));
      release_rsp();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
